// File: rtl/grn_sim_controller.sv
// rtl/grn_sim_controller.sv - sweeps all 2^N initial states through a node network
// and runs tortoise/hare cycle detection on each, emitting steps-to-match per state.
module grn_sim_controller #(
  parameter int N         = 8,
  parameter int STEP_W    = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      state_s0,
  input  logic [N-1:0]      state_s1,
  output logic              reset_nos,
  output logic              start_s0,
  output logic              start_s1,
  output logic [N-1:0]      init_state,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [N-1:0]      result_init,
  output logic [STEP_W-1:0] result_steps,
  output logic              result_timeout,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STEP   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_EMIT   = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(MAX_STEPS);
  localparam logic [N-1:0]      INIT_LAST = '1;

  state_t              state_q;
  logic [N-1:0]        init_q;
  logic [STEP_W-1:0]   step_q;
  logic                reset_nos_q;
  logic                strobe_q;
  logic                valid_q;
  logic                timeout_q;
  logic                done_q;

  // Every strobe is asserted on the transition into its state, so each output
  // is a flop that is high for exactly the cycle the FSM spends in that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      init_q      <= '0;
      step_q      <= '0;
      reset_nos_q <= 1'b0;
      strobe_q    <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      reset_nos_q <= 1'b0;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            init_q      <= '0;
            reset_nos_q <= 1'b1;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          step_q   <= '0;
          strobe_q <= 1'b1;
          state_q  <= ST_STEP;
        end
        ST_STEP: begin
          if (step_q != STEP_MAX) begin
            step_q <= step_q + 1'b1;
          end
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          // Node registers were stepped at the end of STEP and are settled here.
          if (state_s0 == state_s1) begin
            timeout_q <= 1'b0;
            valid_q   <= 1'b1;
            state_q   <= ST_EMIT;
          end else if (step_q == STEP_MAX) begin
            timeout_q <= 1'b1;
            valid_q   <= 1'b1;
            state_q   <= ST_EMIT;
          end else begin
            strobe_q <= 1'b1;
            state_q  <= ST_STEP;
          end
        end
        ST_EMIT: begin
          if (result_ready) begin
            valid_q <= 1'b0;
            if (init_q == INIT_LAST) begin
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end else begin
              init_q      <= init_q + 1'b1;
              reset_nos_q <= 1'b1;
              state_q     <= ST_LOAD;
            end
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign reset_nos      = reset_nos_q;
  assign start_s0       = strobe_q;
  assign start_s1       = strobe_q;
  assign init_state     = init_q;
  assign result_valid   = valid_q;
  assign result_init    = init_q;
  assign result_steps   = step_q;
  assign result_timeout = timeout_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_grn_sim_controller.sv
// tb/tb_grn_sim_controller.sv - directed sweeps on two controller instances
// (N=3/MAX=1000 and N=2/MAX=5) with behavioural node models.
module tb_grn_sim_controller;

  typedef struct {
    int sel;
    int mode;
    int n_init;
    int exp_steps;
    int exp_to;
    int noise;
  } sweep_t;

  logic clk;
  logic rst;
  logic start;
  logic noise_start;
  logic noise_en;
  logic result_ready;
  int   sel;
  int   mode_a;
  int   mode_b;

  logic        a_start, a_reset_nos, a_start_s0, a_start_s1, a_valid, a_to, a_busy, a_done;
  logic [2:0]  a_s0, a_s1, a_init_state, a_rinit;
  logic [15:0] a_steps;
  logic        b_start, b_reset_nos, b_start_s0, b_start_s1, b_valid, b_to, b_busy, b_done;
  logic [1:0]  b_s0, b_s1, b_init_state, b_rinit;
  logic [15:0] b_steps;

  int cur_reset_nos, cur_start_s0, cur_start_s1, cur_valid, cur_to, cur_busy, cur_done;
  int cur_init_state, cur_rinit, cur_steps;

  int total;
  int bad;
  int done_total;

  grn_sim_controller #(.N(3), .STEP_W(16), .MAX_STEPS(1000)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .state_s0(a_s0), .state_s1(a_s1),
    .reset_nos(a_reset_nos), .start_s0(a_start_s0), .start_s1(a_start_s1),
    .init_state(a_init_state), .result_valid(a_valid), .result_ready(result_ready),
    .result_init(a_rinit), .result_steps(a_steps), .result_timeout(a_to),
    .busy(a_busy), .done(a_done)
  );

  grn_sim_controller #(.N(2), .STEP_W(16), .MAX_STEPS(5)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .state_s0(b_s0), .state_s1(b_s1),
    .reset_nos(b_reset_nos), .start_s0(b_start_s0), .start_s1(b_start_s1),
    .init_state(b_init_state), .result_valid(b_valid), .result_ready(result_ready),
    .result_init(b_rinit), .result_steps(b_steps), .result_timeout(b_to),
    .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign a_start = (start | noise_start) && (sel == 0);
  assign b_start = (start | noise_start) && (sel == 1);

  // Node models: mode 0 fixed point, mode 1 counter cycle (hare moves 2),
  // mode 2 hare kept at the complement of the tortoise so they never meet.
  always_ff @(posedge clk) begin
    if (a_reset_nos) begin
      a_s0 <= a_init_state;
      a_s1 <= (mode_a == 2) ? ~a_init_state : a_init_state;
    end else begin
      if (a_start_s0) a_s0 <= (mode_a == 0) ? a_s0 : a_s0 + 3'd1;
      if (a_start_s1) a_s1 <= (mode_a == 0) ? a_s1 : (mode_a == 1) ? a_s1 + 3'd2 : a_s1 - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (b_reset_nos) begin
      b_s0 <= b_init_state;
      b_s1 <= (mode_b == 2) ? ~b_init_state : b_init_state;
    end else begin
      if (b_start_s0) b_s0 <= (mode_b == 0) ? b_s0 : b_s0 + 2'd1;
      if (b_start_s1) b_s1 <= (mode_b == 0) ? b_s1 : (mode_b == 1) ? b_s1 + 2'd2 : b_s1 - 2'd1;
    end
  end

  always_comb begin
    cur_reset_nos  = 0;
    cur_start_s0   = 0;
    cur_start_s1   = 0;
    cur_valid      = 0;
    cur_to         = 0;
    cur_busy       = 0;
    cur_done       = 0;
    cur_init_state = 0;
    cur_rinit      = 0;
    cur_steps      = 0;
    if (sel == 0) begin
      cur_reset_nos  = int'(a_reset_nos);
      cur_start_s0   = int'(a_start_s0);
      cur_start_s1   = int'(a_start_s1);
      cur_valid      = int'(a_valid);
      cur_to         = int'(a_to);
      cur_busy       = int'(a_busy);
      cur_done       = int'(a_done);
      cur_init_state = int'(a_init_state);
      cur_rinit      = int'(a_rinit);
      cur_steps      = int'(a_steps);
    end else begin
      cur_reset_nos  = int'(b_reset_nos);
      cur_start_s0   = int'(b_start_s0);
      cur_start_s1   = int'(b_start_s1);
      cur_valid      = int'(b_valid);
      cur_to         = int'(b_to);
      cur_busy       = int'(b_busy);
      cur_done       = int'(b_done);
      cur_init_state = int'(b_init_state);
      cur_rinit      = int'(b_rinit);
      cur_steps      = int'(b_steps);
    end
  end

  always @(negedge clk) begin
    if (cur_done != 0) done_total <= done_total + 1;
    noise_start <= noise_en && (cur_busy != 0) && ($urandom_range(0, 3) == 0);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 5000 && cur_valid == 0; c++) @(negedge clk);
    chk("valid_seen", cur_valid, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && cur_done == 0; c++) @(negedge clk);
    chk("done_seen", cur_done, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_sweep(input sweep_t v);
    int d0;
    sel = v.sel;
    if (v.sel == 0) mode_a = v.mode; else mode_b = v.mode;
    noise_en = (v.noise != 0);
    d0 = done_total;
    pulse_start();
    for (int i = 0; i < v.n_init; i++) begin
      wait_valid();
      chk("result_init", cur_rinit, i);
      chk("result_steps", cur_steps, v.exp_steps);
      chk("result_timeout", cur_to, v.exp_to);
      @(negedge clk);
    end
    wait_done(20);
    noise_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_idle", cur_busy, 0);
    chk("done_count", done_total - d0, 1);
  endtask

  sweep_t vec [6];

  initial begin
    int snap_init, snap_steps, snap_to, d0;
    total = 0;
    bad = 0;
    done_total = 0;
    rst = 1'b1;
    start = 1'b0;
    noise_en = 1'b0;
    result_ready = 1'b1;
    sel = 0;
    mode_a = 0;
    mode_b = 0;

    vec[0] = '{sel: 1, mode: 0, n_init: 4, exp_steps: 1,    exp_to: 0, noise: 0};
    vec[1] = '{sel: 0, mode: 1, n_init: 8, exp_steps: 8,    exp_to: 0, noise: 0};
    vec[2] = '{sel: 1, mode: 2, n_init: 4, exp_steps: 5,    exp_to: 1, noise: 0};
    vec[3] = '{sel: 0, mode: 0, n_init: 8, exp_steps: 1,    exp_to: 0, noise: 1};
    vec[4] = '{sel: 1, mode: 1, n_init: 4, exp_steps: 4,    exp_to: 0, noise: 1};
    vec[5] = '{sel: 0, mode: 2, n_init: 8, exp_steps: 1000, exp_to: 1, noise: 0};

    #22;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("rst_busy", cur_busy, 0);
      chk("rst_strobes", cur_reset_nos + cur_start_s0 + cur_start_s1, 0);
      chk("rst_valid_done", cur_valid + cur_done + cur_to, 0);
      chk("rst_values", cur_init_state + cur_rinit + cur_steps, 0);
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_sweep(vec[k]);

    // Backpressure: payload must hold and no node activity while ready is low.
    sel = 0;
    mode_a = 0;
    result_ready = 1'b0;
    d0 = done_total;
    pulse_start();
    wait_valid();
    snap_init = cur_rinit;
    snap_steps = cur_steps;
    snap_to = cur_to;
    chk("bp_init", snap_init, 0);
    chk("bp_steps", snap_steps, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid_hold", cur_valid, 1);
      chk("bp_payload_hold", int'(cur_rinit == snap_init && cur_steps == snap_steps && cur_to == snap_to), 1);
      chk("bp_no_strobe", cur_reset_nos + cur_start_s0 + cur_start_s1, 0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", cur_valid, 0);
    chk("bp_next_load", cur_reset_nos, 1);
    chk("bp_next_init", cur_init_state, 1);
    wait_done(200);
    chk("bp_done_count", done_total + int'(cur_done) - d0, 1);
    @(negedge clk);
    @(negedge clk);

    // Reset during STEP of init 3 aborts without a result or done.
    mode_a = 1;
    d0 = done_total;
    pulse_start();
    for (int c = 0; c < 2000 && !(cur_start_s0 != 0 && cur_init_state == 3); c++) @(negedge clk);
    chk("mid_step_reached", int'(cur_start_s0 != 0 && cur_init_state == 3), 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_strobes", cur_reset_nos + cur_start_s0 + cur_start_s1, 0);
    chk("mid_rst_valid_done_busy", cur_valid + cur_done + cur_busy + cur_to, 0);
    chk("mid_rst_values", cur_init_state + cur_rinit + cur_steps, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_no_done", done_total - d0, 0);
    pulse_start();
    for (int c = 0; c < 10 && cur_reset_nos == 0; c++) @(negedge clk);
    chk("restart_load", cur_reset_nos, 1);
    chk("restart_init", cur_init_state, 0);
    wait_done(500);
    @(negedge clk);
    chk("restart_done_count", done_total - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grn_sim_controller.md
GRN_SIM_CONTROLLER -- requirements
Module: grn_sim_controller

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of network nodes (state vector width).
REQ-002 The block SHALL have parameter STEP_W, default 16, giving the width of the step counter.
REQ-003 The block SHALL have parameter MAX_STEPS, default 1000, giving the step limit per initial state before timeout.
REQ-004 One clock; reset is asynchronous and active-high: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have port start  input  1  launches a sweep over all 2^N initial states; sampled only in IDLE.
REQ-006 The block SHALL have port state_s0  input  N  concatenated node s0 (tortoise) registers.
REQ-007 The block SHALL have port state_s1  input  N  concatenated node s1 (hare) registers.
REQ-008 The block SHALL have port reset_nos  output  1  node load strobe.
REQ-009 The block SHALL have port start_s0  output  1  tortoise step strobe.
REQ-010 The block SHALL have port start_s1  output  1  hare step strobe.
REQ-011 The block SHALL have port init_state  output  N  initial state, bit i driving node i.
REQ-012 The block SHALL have port result_valid  output  1  result available.
REQ-013 The block SHALL have port result_ready  input  1  consumer accepts result.
REQ-014 The block SHALL have ports result_init  output  N, result_steps  output  STEP_W and result_timeout  output  1, forming the result payload.
REQ-015 The block SHALL have ports busy  output  1 and done  output  1, where done is a one-cycle end-of-sweep pulse.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, STEP, CHECK, EMIT and FINISH.
REQ-017 IDLE: when start=1, load init counter=0 and go to LOAD; busy=0 only in IDLE.
REQ-018 LOAD: reset_nos=1 for exactly one cycle with init_state=init counter; clear step counter; next state STEP.
REQ-019 STEP: start_s0=start_s1=1 for exactly one cycle; step counter +1; next state CHECK.
REQ-020 CHECK: no strobes asserted, so the node registers have settled; compare state_s0 against state_s1.
REQ-021 CHECK, equal: set result_timeout=0 and go to EMIT.
REQ-022 CHECK, not equal and step counter=MAX_STEPS: set result_timeout=1 and go to EMIT.
REQ-023 CHECK, otherwise: go to STEP.
REQ-024 The comparison SHALL never occur before the first STEP of an initial state; equality right after LOAD SHALL be ignored.
REQ-025 EMIT: result_valid=1 with result_init=init counter and result_steps=step counter; all payload outputs SHALL stay stable until a cycle where result_valid and result_ready are both 1.
REQ-026 On the EMIT handshake cycle: if init counter=2^N-1, go to FINISH; otherwise increment the init counter and go to LOAD.
REQ-027 FINISH: done=1 for one cycle, then go to IDLE.
REQ-028 start SHALL be ignored in every state except IDLE.
REQ-029 reset_nos, start_s0, start_s1, result_valid and done SHALL be registered outputs and mutually exclusive.
REQ-030 reset_nos and start_s0/start_s1 SHALL never be asserted in the same cycle.
REQ-031 The step counter SHALL saturate at MAX_STEPS and never wrap.
REQ-032 The init counter SHALL be N bits; its wrap from 2^N-1 is never taken, because FINISH is entered instead.
REQ-033 init_state SHALL equal the init counter in all states.

Reset
REQ-034 While rst=1, the FSM SHALL be in IDLE and all counters SHALL be 0.
REQ-035 While rst=1, reset_nos, start_s0, start_s1, result_valid, result_timeout, busy and done SHALL be 0, and init_state, result_init and result_steps SHALL be 0.
REQ-036 Reset asserted mid-sweep SHALL abort immediately with no result and no done pulse; the next start restarts from init_state=0.

Verification
REQ-037 Fixed point, N=2: node model with next state = current state; start -> per init 1 LOAD, 1 STEP, match; 4 results each with result_steps=1 and timeout=0, then done pulses once.
REQ-038 Cycle, N=3: model with next = state+1 mod 8, MAX_STEPS=1000 -> each init state gives match at result_steps=8 and timeout=0.
REQ-039 Timeout: model with no match and MAX_STEPS=5 -> result_steps=5 and timeout=1 for every init state.
REQ-040 Backpressure: hold result_ready=0 for 10 cycles in EMIT -> payload stable, no strobes issued, advance on the first ready cycle.
REQ-041 Reset mid-operation: assert rst during STEP of init 3 -> all outputs 0 asynchronously; after release and a new start, the first LOAD has init_state=0.
REQ-042 Ignored start: pulse start while busy -> no effect on sequence; exactly one done per sweep.
